// File: rtl/term_pkg.sv
// rtl/term_pkg.sv - shared constants, attribute type and FSM encoding for the terminal controller
package term_pkg;

    localparam logic [7:0] C_BS  = 8'h08;
    localparam logic [7:0] C_TAB = 8'h09;
    localparam logic [7:0] C_LF  = 8'h0A;
    localparam logic [7:0] C_CR  = 8'h0D;
    localparam logic [7:0] C_ESC = 8'h1B;

    localparam logic [7:0] CMD_POS    = 8'h59;  // 'Y'
    localparam logic [7:0] CMD_FG     = 8'h46;  // 'F'
    localparam logic [7:0] CMD_BG     = 8'h42;  // 'B'
    localparam logic [7:0] CMD_UL_ON  = 8'h55;  // 'U'
    localparam logic [7:0] CMD_UL_OFF = 8'h75;  // 'u'
    localparam logic [7:0] CMD_CUR    = 8'h43;  // 'C'
    localparam logic [7:0] CMD_CLR    = 8'h4A;  // 'J'

    localparam int ROWS_DEF = 30;
    localparam int COLS_DEF = 80;

    localparam logic [1:0] DT_CHAR = 2'd0;
    localparam logic [1:0] DT_COL  = 2'd1;
    localparam logic [1:0] DT_ROW  = 2'd2;

    typedef struct packed {
        logic [11:0] fg;
        logic [11:0] bg;
        logic        underln;
        logic        curvis;
        logic        curblk;
    } attr_t;

    localparam attr_t ATTR_RESET = '{fg: 12'hFFF, bg: 12'h000, underln: 1'b0,
                                     curvis: 1'b1, curblk: 1'b1};

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DISPATCH = 3'd1;
    localparam logic [2:0] ST_ESC      = 3'd2;
    localparam logic [2:0] ST_ARG1     = 3'd3;
    localparam logic [2:0] ST_ARG2     = 3'd4;
    localparam logic [2:0] ST_WR       = 3'd5;
    localparam logic [2:0] ST_CLR      = 3'd6;

    // Cursor-address argument: byte minus 0x20, floored at 0, clamped to limit.
    function automatic logic [7:0] clamp_arg(input logic [7:0] b, input logic [7:0] limit);
        logic [7:0] v;
        v = (b < 8'h20) ? 8'h00 : b - 8'h20;
        return (v > limit) ? limit : v;
    endfunction

endpackage

// File: rtl/term_ctrl_if.sv
// rtl/term_ctrl_if.sv - byte input stream, core latch interface and attribute outputs
interface term_ctrl_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  currow;
    logic [6:0]  curcol;
    logic [7:0]  data;
    logic [1:0]  dtype;
    logic        dstrobe;
    logic [11:0] fgclr;
    logic [11:0] bgclr;
    logic        underln;
    logic        curvis;
    logic        curblk;
    logic        busy;

    modport master (
        input  in_data, in_valid, currow, curcol,
        output in_ready, data, dtype, dstrobe, fgclr, bgclr, underln, curvis, curblk, busy
    );

    modport slave (
        output in_data, in_valid, currow, curcol,
        input  in_ready, data, dtype, dstrobe, fgclr, bgclr, underln, curvis, curblk, busy
    );
endinterface

// File: rtl/term_strobe_gen.sv
// rtl/term_strobe_gen.sv - one core write: SETUP, STROBE_HI cycles high, STROBE_LO cycles low
module term_strobe_gen #(
    parameter int STROBE_HI = 8,
    parameter int STROBE_LO = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] start_data,
    input  logic [1:0] start_type,
    output logic [7:0] data,
    output logic [1:0] dtype,
    output logic       dstrobe,
    output logic       idle,
    output logic       done
);
    localparam int CW = $clog2((STROBE_HI > STROBE_LO) ? STROBE_HI : STROBE_LO) + 1;
    localparam logic [CW-1:0] HI_LAST = CW'(STROBE_HI - 1);
    localparam logic [CW-1:0] LO_LAST = CW'(STROBE_LO - 1);

    localparam logic [1:0] G_IDLE  = 2'd0;
    localparam logic [1:0] G_SETUP = 2'd1;
    localparam logic [1:0] G_HI    = 2'd2;
    localparam logic [1:0] G_LO    = 2'd3;

    logic [1:0]    phase;
    logic [CW-1:0] cnt;

    assign idle = (phase == G_IDLE);
    assign done = (phase == G_LO) && (cnt == LO_LAST);

    // dstrobe is a flop so the core sees a clean edge; async reset drops it at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= G_IDLE;
            cnt     <= '0;
            data    <= '0;
            dtype   <= '0;
            dstrobe <= 1'b0;
        end else if (start && (idle || done)) begin
            phase   <= G_SETUP;
            cnt     <= '0;
            data    <= start_data;
            dtype   <= start_type;
            dstrobe <= 1'b0;
        end else begin
            case (phase)
                G_SETUP: begin
                    phase   <= G_HI;
                    cnt     <= '0;
                    dstrobe <= 1'b1;
                end
                G_HI: begin
                    if (cnt == HI_LAST) begin
                        phase   <= G_LO;
                        cnt     <= '0;
                        dstrobe <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                G_LO: begin
                    if (cnt == LO_LAST) begin
                        phase <= G_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/term_ctrl.sv
// rtl/term_ctrl.sv - byte-stream interpreter driving the VGA character terminal core
module term_ctrl
    import term_pkg::*;
#(
    parameter int STROBE_HI = 8,
    parameter int STROBE_LO = 8,
    parameter int ROWS      = ROWS_DEF,
    parameter int COLS      = COLS_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    term_ctrl_if.master bus
);
    localparam logic [7:0]  ROW_MAX   = 8'(ROWS - 1);
    localparam logic [7:0]  COL_MAX   = 8'(COLS - 1);
    localparam logic [11:0] CELL_LAST = 12'(ROWS * COLS - 1);
    localparam logic [2:0]  CLR_END   = 3'd5;

    logic [2:0]  state;
    logic [7:0]  byte_q;
    logic [7:0]  cmd_q;
    logic [7:0]  arg1_q;
    logic        pos_q;
    logic [7:0]  nxt_data;
    logic [1:0]  nxt_type;
    logic        nxt_valid;
    logic [2:0]  clr_step;
    logic [11:0] clr_cnt;
    attr_t       attr;

    logic        st_start;
    logic [7:0]  st_data;
    logic [1:0]  st_type;
    logic        st_idle;
    logic        st_done;
    logic [7:0]  gen_data;
    logic [1:0]  gen_dtype;
    logic        gen_dstrobe;

    logic        accept;
    logic [7:0]  row_next;
    logic [7:0]  tab_raw;
    logic [7:0]  tab_col;

    assign bus.in_ready = (state == ST_IDLE) || (state == ST_ESC) ||
                          (state == ST_ARG1) || (state == ST_ARG2);
    assign bus.busy     = ~bus.in_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign row_next = ({3'b000, bus.currow} == ROW_MAX) ? 8'd0 : {3'b000, bus.currow} + 8'd1;
    assign tab_raw  = ({1'b0, bus.curcol} | 8'h07) + 8'h01;
    assign tab_col  = (tab_raw > COL_MAX) ? COL_MAX : tab_raw;

    // Writes are issued combinationally so a new one starts on the edge the previous one ends.
    always_comb begin
        st_start = 1'b0;
        st_data  = '0;
        st_type  = DT_CHAR;
        case (state)
            ST_DISPATCH: begin
                if (pos_q) begin
                    st_start = 1'b1;
                    st_type  = DT_ROW;
                    st_data  = clamp_arg(arg1_q, ROW_MAX);
                end else if (byte_q == C_CR) begin
                    st_start = 1'b1;
                    st_type  = DT_COL;
                end else if (byte_q == C_LF) begin
                    st_start = 1'b1;
                    st_type  = DT_ROW;
                    st_data  = row_next;
                end else if (byte_q == C_BS) begin
                    if (bus.curcol != 7'd0) begin
                        st_start = 1'b1;
                        st_type  = DT_COL;
                        st_data  = {1'b0, bus.curcol} - 8'd1;
                    end
                end else if (byte_q == C_TAB) begin
                    st_start = 1'b1;
                    st_type  = DT_COL;
                    st_data  = tab_col;
                end else if (byte_q >= 8'h20 && byte_q != 8'h7F) begin
                    st_start = 1'b1;
                    st_data  = byte_q;
                end
            end
            ST_WR: begin
                if (st_done && nxt_valid) begin
                    st_start = 1'b1;
                    st_type  = nxt_type;
                    st_data  = nxt_data;
                end
            end
            ST_CLR: begin
                if ((st_idle || st_done) && clr_step != CLR_END) begin
                    st_start = 1'b1;
                    case (clr_step)
                        3'd0, 3'd3: st_type = DT_ROW;
                        3'd1, 3'd4: st_type = DT_COL;
                        default: begin
                            st_type = DT_CHAR;
                            st_data = 8'h20;
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            byte_q    <= '0;
            cmd_q     <= '0;
            arg1_q    <= '0;
            pos_q     <= 1'b0;
            nxt_data  <= '0;
            nxt_type  <= DT_CHAR;
            nxt_valid <= 1'b0;
            clr_step  <= '0;
            clr_cnt   <= '0;
            attr      <= ATTR_RESET;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        byte_q <= bus.in_data;
                        state  <= (bus.in_data == C_ESC) ? ST_ESC : ST_DISPATCH;
                    end
                end
                ST_ESC: begin
                    if (accept) begin
                        cmd_q <= bus.in_data;
                        case (bus.in_data)
                            CMD_POS, CMD_FG, CMD_BG, CMD_CUR: state <= ST_ARG1;
                            CMD_UL_ON: begin
                                attr.underln <= 1'b1;
                                state        <= ST_IDLE;
                            end
                            CMD_UL_OFF: begin
                                attr.underln <= 1'b0;
                                state        <= ST_IDLE;
                            end
                            CMD_CLR: begin
                                clr_step <= '0;
                                clr_cnt  <= '0;
                                state    <= ST_CLR;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                ST_ARG1: begin
                    if (accept) begin
                        arg1_q <= bus.in_data;
                        if (cmd_q == CMD_CUR) begin
                            attr.curvis <= bus.in_data[0];
                            attr.curblk <= bus.in_data[1];
                            state       <= ST_IDLE;
                        end else begin
                            state <= ST_ARG2;
                        end
                    end
                end
                ST_ARG2: begin
                    if (accept) begin
                        case (cmd_q)
                            CMD_FG: begin
                                attr.fg <= {arg1_q[3:0], bus.in_data};
                                state   <= ST_IDLE;
                            end
                            CMD_BG: begin
                                attr.bg <= {arg1_q[3:0], bus.in_data};
                                state   <= ST_IDLE;
                            end
                            default: begin
                                byte_q <= bus.in_data;
                                pos_q  <= 1'b1;
                                state  <= ST_DISPATCH;
                            end
                        endcase
                    end
                end
                ST_DISPATCH: begin
                    // Cursor addressing queues the column write behind the row write.
                    pos_q <= 1'b0;
                    if (pos_q) begin
                        nxt_valid <= 1'b1;
                        nxt_data  <= clamp_arg(byte_q, COL_MAX);
                        nxt_type  <= DT_COL;
                    end
                    state <= st_start ? ST_WR : ST_IDLE;
                end
                ST_WR: begin
                    if (st_done) begin
                        if (nxt_valid) begin
                            nxt_valid <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_CLR: begin
                    if (st_start) begin
                        if (clr_step == 3'd2) begin
                            if (clr_cnt == CELL_LAST) begin
                                clr_step <= 3'd3;
                            end else begin
                                clr_cnt <= clr_cnt + 12'd1;
                            end
                        end else begin
                            clr_step <= clr_step + 3'd1;
                        end
                    end else if (clr_step == CLR_END && st_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    term_strobe_gen #(
        .STROBE_HI (STROBE_HI),
        .STROBE_LO (STROBE_LO)
    ) u_strobe (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (st_start),
        .start_data (st_data),
        .start_type (st_type),
        .data       (gen_data),
        .dtype      (gen_dtype),
        .dstrobe    (gen_dstrobe),
        .idle       (st_idle),
        .done       (st_done)
    );

    assign bus.data    = gen_data;
    assign bus.dtype   = gen_dtype;
    assign bus.dstrobe = gen_dstrobe;
    assign bus.fgclr   = attr.fg;
    assign bus.bgclr   = attr.bg;
    assign bus.underln = attr.underln;
    assign bus.curvis  = attr.curvis;
    assign bus.curblk  = attr.curblk;
endmodule

// File: tb/tb_term_ctrl.sv
// tb/tb_term_ctrl.sv - directed and randomized checks of term_ctrl against a byte-level model
module tb_term_ctrl;
    localparam int BOUND = 60000;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;

    term_ctrl_if bus ();

    term_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [9:0]  obs_q[$];
    logic [9:0]  exp_q[$];
    logic        prev_ds = 1'b0;
    logic [9:0]  hi_word = '0;
    int          hi_len = 0;
    int          rise_cyc = 0;
    int          last_rise = -1000;
    int          width_bad = 0;
    int          gap_bad = 0;
    int          stab_bad = 0;
    logic [11:0] fg_at_rise = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_ds = 1'b0;
            hi_len  = 0;
        end else begin
            if (bus.dstrobe && !prev_ds) begin
                hi_word = {bus.dtype, bus.data};
                obs_q.push_back(hi_word);
                fg_at_rise = bus.fgclr;
                if (cyc - last_rise < 17) gap_bad++;
                last_rise = cyc;
                rise_cyc  = cyc;
                hi_len    = 1;
            end else if (bus.dstrobe) begin
                hi_len++;
                if ({bus.dtype, bus.data} != hi_word) stab_bad++;
            end
            if (!bus.dstrobe && prev_ds && hi_len != 8) width_bad++;
            prev_ds = bus.dstrobe;
        end
    end

    // Reference model: byte-level behaviour of the terminal, independent of the FSM.
    int          m_st;
    logic [7:0]  m_cmd, m_a1;
    logic [11:0] m_fg, m_bg;
    logic        m_ul, m_cv, m_cb;

    task automatic model_reset();
        m_st = 0; m_cmd = 0; m_a1 = 0;
        m_fg = 12'hFFF; m_bg = 12'h000; m_ul = 0; m_cv = 1; m_cb = 1;
    endtask

    task automatic push_w(input int t, input int d);
        exp_q.push_back({t[1:0], d[7:0]});
    endtask

    function automatic int mclamp(input int b, input int hi);
        int v;
        v = b - 32;
        if (v < 0) v = 0;
        if (v > hi) v = hi;
        return v;
    endfunction

    task automatic model_feed(input logic [7:0] b, input int row, input int col);
        int t;
        case (m_st)
            0: begin
                if (b == 8'h1B) m_st = 1;
                else if (b >= 8'h20 && b != 8'h7F) push_w(0, b);
                else if (b == 8'h0D) push_w(1, 0);
                else if (b == 8'h0A) push_w(2, (row == 29) ? 0 : row + 1);
                else if (b == 8'h08) begin
                    if (col > 0) push_w(1, col - 1);
                end else if (b == 8'h09) begin
                    t = (col / 8 + 1) * 8;
                    push_w(1, (t > 79) ? 79 : t);
                end
            end
            1: begin
                m_cmd = b;
                m_st  = 0;
                if (b == "Y" || b == "F" || b == "B" || b == "C") m_st = 2;
                else if (b == "U") m_ul = 1;
                else if (b == "u") m_ul = 0;
                else if (b == "J") begin
                    push_w(2, 0); push_w(1, 0);
                    for (int i = 0; i < 30 * 80; i++) push_w(0, 32);
                    push_w(2, 0); push_w(1, 0);
                end
            end
            2: begin
                m_a1 = b;
                if (m_cmd == "C") begin
                    m_cv = b[0]; m_cb = b[1]; m_st = 0;
                end else m_st = 3;
            end
            default: begin
                m_st = 0;
                if (m_cmd == "F") m_fg = {m_a1[3:0], b};
                else if (m_cmd == "B") m_bg = {m_a1[3:0], b};
                else begin
                    push_w(2, mclamp(m_a1, 29));
                    push_w(1, mclamp(b, 79));
                end
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    int acc_cyc;

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk("send_wait_bound", (n < BOUND), 1);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
        model_feed(b, int'(bus.currow), int'(bus.curcol));
    endtask

    task automatic wait_idle(output int rc);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        #1;
        rc = cyc;
        chk("idle_wait_bound", (n < BOUND), 1);
    endtask

    task automatic compare_writes(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) chk(tag, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_attr(input string tag);
        chk(tag, {bus.fgclr, bus.bgclr, bus.underln, bus.curvis, bus.curblk},
            {m_fg, m_bg, m_ul, m_cv, m_cb});
    endtask

    initial begin
        int rc, n, viol, k, nargs;
        logic [7:0] b;
        logic [7:0] cmds[7];
        cmds = '{8'h59, 8'h46, 8'h42, 8'h55, 8'h75, 8'h43, 8'h51};

        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.currow   = 5'd0;
        bus.curcol   = 7'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_dstrobe", bus.dstrobe, 0);
        chk("rst_data_dtype", {bus.dtype, bus.data}, 0);
        chk("rst_attr", {bus.fgclr, bus.bgclr, bus.underln, bus.curvis, bus.curblk},
            {12'hFFF, 12'h000, 3'b011});
        reset_n = 1'b1;

        // Single printable character: latency and write length.
        send_byte(8'h41);
        wait_idle(rc);
        chk("a_rise_offset", rise_cyc - acc_cyc, 2);
        chk("a_ready_offset", rc - acc_cyc, 18);
        chk("a_word", obs_q[0], {2'd0, 8'h41});
        compare_writes("char_a");

        bus.currow = 5'd29; bus.curcol = 7'd10;
        send_byte(8'h0A);
        wait_idle(rc);
        chk("lf_bottom_word", obs_q[0], {2'd2, 8'd0});
        compare_writes("lf_bottom");

        bus.curcol = 7'd0;
        send_byte(8'h08);
        wait_idle(rc);
        chk("bs_col0_ready", rc - acc_cyc, 1);
        compare_writes("bs_col0");

        send_byte(8'h1B); send_byte(8'h59); send_byte(8'h3F); send_byte(8'h70);
        wait_idle(rc);
        chk("pos_row_word", obs_q[0], {2'd2, 8'd29});
        chk("pos_col_word", obs_q[1], {2'd1, 8'd79});
        compare_writes("pos_clamp");

        send_byte(8'h1B); send_byte(8'h46); send_byte(8'h0F); send_byte(8'h80);
        send_byte(8'h78);
        wait_idle(rc);
        chk("fg_before_rise", fg_at_rise, 12'hF80);
        compare_writes("fg_char");
        chk_attr("fg_attr");

        send_byte(8'h1B); send_byte(8'h51);
        wait_idle(rc);
        chk("esc_q_idle", {bus.in_ready, bus.busy}, 2'b10);
        compare_writes("esc_q");

        // Random bytes and ESC sequences against the model.
        for (int it = 0; it < 60; it++) begin
            bus.currow = 5'($urandom_range(0, 29));
            bus.curcol = 7'($urandom_range(0, 79));
            if ($urandom_range(0, 2) != 0) begin
                k = $urandom_range(0, 5);
                b = (k == 0) ? 8'h0D : (k == 1) ? 8'h0A : (k == 2) ? 8'h08 :
                    (k == 3) ? 8'h09 : 8'($urandom_range(0, 255));
                if (b == 8'h1B) b = 8'h1A;
                send_byte(b);
            end else begin
                k = $urandom_range(0, 6);
                nargs = (k <= 2) ? 2 : (k == 5) ? 1 : 0;
                send_byte(8'h1B);
                send_byte(cmds[k]);
                for (int a = 0; a < nargs; a++)
                    send_byte(($urandom_range(0, 7) == 0) ? 8'h1B : 8'($urandom_range(0, 255)));
            end
            wait_idle(rc);
            compare_writes("rand_writes");
            chk_attr("rand_attr");
        end

        // Full clear.
        send_byte(8'h1B); send_byte(8'h4A);
        viol = 0;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < BOUND) begin
            if (!bus.busy) viol++;
            @(negedge clk);
            n++;
        end
        #1;
        chk("clr_bound", (n < BOUND), 1);
        chk("clr_busy_throughout", viol, 0);
        chk("clr_duration", cyc - acc_cyc, 1 + 2404 * 17);
        chk("clr_busy_after", bus.busy, 0);
        compare_writes("clr");

        // Reset during the 100th clear pulse.
        send_byte(8'h1B); send_byte(8'h55);
        send_byte(8'h1B); send_byte(8'h4A);
        n = 0;
        while (obs_q.size() < 100 && n < BOUND) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("clr100_bound", (n < BOUND), 1);
        chk("clr100_high", bus.dstrobe, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_dstrobe", bus.dstrobe, 0);
        chk("abort_attr", {bus.fgclr, bus.bgclr, bus.underln, bus.curvis, bus.curblk},
            {12'hFFF, 12'h000, 3'b011});
        chk("abort_busy", bus.busy, 0);
        for (int i = 0; i < 100; i++) chk("clr_prefix", obs_q[i], exp_q[i]);
        chk("clr_prefix_count", obs_q.size(), 100);
        obs_q.delete();
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("post_rst_ready", {bus.in_ready, bus.busy, bus.dstrobe}, 3'b100);
        chk("post_rst_no_pulse", obs_q.size(), 0);

        chk("pulse_width", width_bad, 0);
        chk("pulse_spacing", gap_bad, 0);
        chk("pulse_stable", stab_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
